// File: rtl/sha_msg_padder_if.sv
// Message-word input stream and padded-block output of the SHA-256 padder.
// With SHA_PAD_W64_EN defined the interface also carries the expanded schedule blk_w64.
interface sha_msg_padder_if;
  // Both channels are valid/ready: the source raises valid and holds its payload
  // unchanged until the cycle where valid & ready are both high; that cycle is the transfer.
  logic [31:0]       in_data;
  logic [2:0]        in_nbytes;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [0:15][31:0] blk_data;
  logic              blk_first;
  logic              blk_last;
  logic              blk_valid;
  logic              blk_ready;
`ifdef SHA_PAD_W64_EN
  logic [0:63][31:0] blk_w64;
`endif

  modport slave (
    input  in_data, in_nbytes, in_last, in_valid, blk_ready,
    output in_ready, blk_data, blk_first, blk_last, blk_valid
`ifdef SHA_PAD_W64_EN
    , output blk_w64
`endif
  );

  modport master (
    output in_data, in_nbytes, in_last, in_valid, blk_ready,
    input  in_ready, blk_data, blk_first, blk_last, blk_valid
`ifdef SHA_PAD_W64_EN
    , input blk_w64
`endif
  );
endinterface

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks with 0x80 marker and bit length.
// Optional SHA_PAD_W64_EN adds the combinational message schedule W[0..63] on blk_w64.
module sha_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  sha_msg_padder_if.slave   bus,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_FILL       = 3'd0,
    S_SEND       = 3'd1,
    S_SEND_LAST  = 3'd2,
    S_SEND_PRE   = 3'd3,
    S_SEND_EXTRA = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [0:15][31:0] buf_q, buf_d;
  logic [3:0]        idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              first_q, first_d;
  logic              pad0_q, pad0_d;

  logic              sending, accept, hs;
  logic [LEN_W-1:0]  len_new;
  logic [63:0]       len_ext;
  logic [31:0]       last_word;
  logic [4:0]        pad_idx;

  assign sending = (state_q != S_FILL);
  assign accept  = bus.in_valid && (state_q == S_FILL);
  assign hs      = sending && bus.blk_ready;
  assign len_new = len_q + LEN_W'({bus.in_nbytes, 3'b000});
  assign pad_idx = bus.in_nbytes[2] ? ({1'b0, idx_q} + 5'd1) : {1'b0, idx_q};

  always_comb begin
    len_ext = '0;
    len_ext[LEN_W-1:0] = sending ? len_q : len_new;
  end

  // Partial tail word: keep the valid top bytes, marker in the first free byte.
  always_comb begin
    last_word = bus.in_data;
    case (bus.in_nbytes)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {bus.in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {bus.in_data[31:16], 16'h8000};
      3'd3:    last_word = {bus.in_data[31:8], 8'h80};
      default: last_word = bus.in_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    len_d   = len_q;
    first_d = first_q;
    pad0_d  = pad0_q;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          buf_d[idx_q] = bus.in_last ? last_word : bus.in_data;
          idx_d        = idx_q + 4'd1;
          len_d        = len_new;
          if (bus.in_last) begin
            if (bus.in_nbytes[2] && !pad_idx[4]) buf_d[pad_idx[3:0]] = 32'h8000_0000;
            if (pad_idx <= 5'd13) begin
              buf_d[14] = len_ext[63:32];
              buf_d[15] = len_ext[31:0];
              state_d   = S_SEND_LAST;
            end else begin
              pad0_d  = pad_idx[4];
              state_d = S_SEND_PRE;
            end
          end else if (idx_q == 4'd15) begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (hs) begin
          buf_d   = '0;
          idx_d   = '0;
          first_d = 1'b0;
          state_d = S_FILL;
        end
      end
      S_SEND_PRE: begin
        if (hs) begin
          buf_d     = '0;
          buf_d[0]  = pad0_q ? 32'h8000_0000 : 32'h0;
          buf_d[14] = len_ext[63:32];
          buf_d[15] = len_ext[31:0];
          first_d   = 1'b0;
          state_d   = S_SEND_EXTRA;
        end
      end
      S_SEND_LAST, S_SEND_EXTRA: begin
        if (hs) begin
          buf_d   = '0;
          idx_d   = '0;
          len_d   = '0;
          first_d = 1'b1;
          pad0_d  = 1'b0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
      buf_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      first_q <= 1'b1;
      pad0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      first_q <= first_d;
      pad0_q  <= pad0_d;
    end
  end

  // Outputs are forced idle while reset is held, not just after the reset edge.
  assign bus.in_ready  = (state_q == S_FILL) && !reset;
  assign bus.blk_valid = sending && !reset;
  assign bus.blk_first = sending && first_q && !reset;
  assign bus.blk_last  = ((state_q == S_SEND_LAST) || (state_q == S_SEND_EXTRA)) && !reset;
  assign bus.blk_data  = reset ? '0 : buf_q;
  assign state_o       = state_q;

`ifdef SHA_PAD_W64_EN
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_comb begin
    logic [0:63][31:0] w;
    w       = '0;
    w[0:15] = bus.blk_data;
    for (int t = 16; t < 64; t++) begin
      w[t] = sig1(w[t-2]) + w[t-7] + sig0(w[t-15]) + w[t-16];
    end
    bus.blk_w64 = w;
  end
`endif

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder: driver tasks push expected blocks, a monitor pops and compares.
module tb_sha_msg_padder;
  localparam int EW = 514;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state_o;

  sha_msg_padder_if bus ();

  sha_msg_padder #(.LEN_W(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  logic [EW-1:0]     exp_q[$];
  logic [EW-1:0]     mon_e;
  logic [0:15][31:0] eb;
  logic [0:15][31:0] abc_blk;
  logic [31:0]       msg [0:15];
  int                pass_cnt = 0;
  int                chk_cnt  = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] pack(input logic [0:15][31:0] d, input logic f, input logic l);
    return {d, f, l};
  endfunction

`ifdef SHA_PAD_W64_EN
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [0:63][31:0] sched(input logic [0:15][31:0] b);
    logic [0:63][31:0] w;
    logic [31:0] s0, s1;
    w = '0;
    for (int t = 0; t < 16; t++) w[t] = b[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    return w;
  endfunction
`endif

  // Monitor: every held block must block input; each handshake consumes one expected block.
  always @(negedge clk) begin
    if (!reset && bus.blk_valid) begin
      check("in_ready_low_while_held", EW'(bus.in_ready), EW'(1'b0));
      if (bus.blk_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_block: got %h expected none", bus.blk_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("block", pack(bus.blk_data, bus.blk_first, bus.blk_last), mon_e);
`ifdef SHA_PAD_W64_EN
          begin
            logic [0:63][31:0] ew;
            int bad;
            ew  = sched(mon_e[EW-1:2]);
            bad = 63;
            for (int t = 63; t >= 0; t--) if (bus.blk_w64[t] !== ew[t]) bad = t;
            check($sformatf("w64[%0d]", bad), EW'(bus.blk_w64[bad]), EW'(ew[bad]));
          end
`endif
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [2:0] n, input logic l);
    int t;
    @(negedge clk);
    bus.in_data   = d;
    bus.in_nbytes = n;
    bus.in_last   = l;
    bus.in_valid  = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk_cnt++;
      $display("FAIL in_ready_timeout: in_ready=0 required 1");
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic end_msg();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input int nw, input logic [2:0] last_n);
    for (int k = 0; k < nw; k++) begin
      send_word(msg[k], (k == nw - 1) ? last_n : 3'd4, k == nw - 1);
    end
    end_msg();
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain_timeout: %0d blocks outstanding required 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_nbytes = '0;
    bus.in_last   = 1'b0;
    bus.blk_ready = 1'b1;
    for (int k = 0; k < 16; k++)
      msg[k] = {8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3), 8'(4 * k + 4)};
    abc_blk     = '0;
    abc_blk[0]  = 32'h6162_6380;
    abc_blk[15] = 32'h0000_0018;

    // Reset state
    repeat (2) @(negedge clk);
    check("in_ready_during_reset", EW'(bus.in_ready), EW'(1'b0));
    check("blk_valid_during_reset", EW'(bus.blk_valid), EW'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", EW'(bus.in_ready), EW'(1'b1));
    check("blk_valid_after_reset", EW'(bus.blk_valid), EW'(1'b0));
    check("blk_after_reset", pack(bus.blk_data, bus.blk_first, bus.blk_last), '0);
    check("state_after_reset", EW'(state_o), EW'(3'd0));

    // "abc"
    exp_q.push_back(pack(abc_blk, 1'b1, 1'b1));
    send_word(32'h6162_6300, 3'd3, 1'b1);
    end_msg();
    wait_drain();

    // Empty message
    eb = '0; eb[0] = 32'h8000_0000;
    exp_q.push_back(pack(eb, 1'b1, 1'b1));
    send_word(32'h0, 3'd0, 1'b1);
    end_msg();
    wait_drain();

    // 10-byte message, 2-byte tail word
    eb = '0;
    eb[0] = 32'h1122_3344; eb[1] = 32'h5566_7788; eb[2] = 32'hAABB_8000; eb[15] = 32'h50;
    exp_q.push_back(pack(eb, 1'b1, 1'b1));
    send_word(32'h1122_3344, 3'd4, 1'b0);
    send_word(32'h5566_7788, 3'd4, 1'b0);
    send_word(32'hAABB_CCDD, 3'd2, 1'b1);
    end_msg();
    wait_drain();

    // 56-byte message: marker fills word 14, length spills to extra block
    eb = '0;
    for (int k = 0; k < 14; k++) eb[k] = msg[k];
    eb[14] = 32'h8000_0000;
    exp_q.push_back(pack(eb, 1'b1, 1'b0));
    eb = '0; eb[15] = 32'h1C0;
    exp_q.push_back(pack(eb, 1'b0, 1'b1));
    send_msg(14, 3'd4);
    wait_drain();

    // 58-byte message: partial tail at word 14, marker inside it
    eb = '0;
    for (int k = 0; k < 14; k++) eb[k] = msg[k];
    eb[14] = {msg[14][31:16], 16'h8000};
    exp_q.push_back(pack(eb, 1'b1, 1'b0));
    eb = '0; eb[15] = 32'h1D0;
    exp_q.push_back(pack(eb, 1'b0, 1'b1));
    send_msg(15, 3'd2);
    wait_drain();

    // 64-byte message: marker lands in extra block word 0
    eb = '0;
    for (int k = 0; k < 16; k++) eb[k] = msg[k];
    exp_q.push_back(pack(eb, 1'b1, 1'b0));
    eb = '0; eb[0] = 32'h8000_0000; eb[15] = 32'h200;
    exp_q.push_back(pack(eb, 1'b0, 1'b1));
    send_msg(16, 3'd4);
    wait_drain();

    // Backpressure: block held for 10 cycles
    @(posedge clk);
    #1 bus.blk_ready = 1'b0;
    exp_q.push_back(pack(abc_blk, 1'b1, 1'b1));
    send_word(32'h6162_6300, 3'd3, 1'b1);
    end_msg();
    begin
      int t;
      t = 0;
      while (!bus.blk_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    check("bp_valid_rise", EW'(bus.blk_valid), EW'(1'b1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", c), EW'(bus.blk_valid), EW'(1'b1));
      check($sformatf("bp_block_c%0d", c), pack(bus.blk_data, bus.blk_first, bus.blk_last),
            pack(abc_blk, 1'b1, 1'b1));
    end
    @(posedge clk);
    #1 bus.blk_ready = 1'b1;
    wait_drain();

    // Reset mid-message, then "abc"
    for (int k = 0; k < 5; k++) send_word(32'hDEAD_0000 | 32'(k), 3'd4, 1'b0);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("in_ready_mid_reset", EW'(bus.in_ready), EW'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("state_after_mid_reset", EW'(state_o), EW'(3'd0));
    exp_q.push_back(pack(abc_blk, 1'b1, 1'b1));
    send_word(32'h6162_6300, 3'd3, 1'b1);
    end_msg();
    wait_drain();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
- Transmit side of the SHA-256 compression core's block interface.
- Accepts a big-endian 32-bit message word stream and applies FIPS 180-4 padding: 0x80 marker, zero fill, and 64-bit bit length.
- Emits complete 512-bit blocks (16 words) to the hash core, one valid/ready handshake per block.
- Sits between the message source and the core; generates the extra trailing block when the length does not fit.

Parameters:
- LEN_W, 64, width of internal bit-length counter; zero-extended into words 14-15; must be at most 64.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  32  message word, big-endian, first byte in [31:24]
- in_nbytes  input  3  valid bytes in in_data, 1-4; 0 legal only with in_last (empty tail word)
- in_last  input  1  final word of message
- in_valid  input  1  in_data, in_nbytes and in_last are valid
- in_ready  output  1  padder accepts input this cycle
- blk_data  output  [0:15][31:0]  padded block, word 0 first
- blk_first  output  1  block is the first of its message (core loads H0)
- blk_last  output  1  block is the final block of its message
- blk_valid  output  1  blk_data, blk_first and blk_last are valid
- blk_ready  input  1  core accepts block

Behaviour:
- Reset (synchronous, active-high) values:
  - blk_valid=0, blk_first=0, blk_last=0, blk_data=0, in_ready=0 during reset.
  - Word index=0, bit count=0, first flag=1, state=S_FILL.
  - Reset mid-message or mid-handshake discards all buffered data. The next accepted word starts a new message.
- States:
  - S_FILL: in_ready=1, blk_valid=0.
  - S_SEND: holds a non-final block.
  - S_SEND_LAST: holds a final block.
  - S_SEND_PRE: holds the last data block when an extra block is still required.
  - S_SEND_EXTRA: holds the extra length block.
- Accepting a word (in_valid & in_ready):
  - Word is written to buf[idx], idx increments.
  - bit count += 8*in_nbytes, wrapping modulo 2^LEN_W.
- Non-last word at idx=15: go to S_SEND.
- Last word at idx=i with n bytes; the block register is updated in the same accept cycle:
  - n<4: keep the top n bytes, byte n=0x80, lower bytes 0. Pad index p=i.
  - n=4: buf[i]=data. 0x80000000 goes at p=i+1.
  - Words after p are zero.
  - p<=13: words 14-15 = {bit count incl. this word}, high word first; go to S_SEND_LAST.
  - p=14 or 15: go to S_SEND_PRE.
  - p=16: 0x80 belongs to the extra block; go to S_SEND_PRE.
- Extra block: words 0-13 zero (word0=0x80000000 if p=16), words 14-15 = length.
- Handshake:
  - blk_valid=1 in every S_SEND* state.
  - blk_data, blk_first and blk_last are held stable until blk_valid & blk_ready.
  - in_ready=0 in all S_SEND* states.
- Transitions on handshake:
  - S_SEND -> S_FILL: clear buffer, idx=0, first flag=0.
  - S_SEND_PRE -> S_SEND_EXTRA: block register loaded with the extra block; first flag=0.
  - S_SEND_LAST or S_SEND_EXTRA -> S_FILL: clear buffer and counters; first flag=1.
- Flags:
  - blk_first = first flag at the time the block is presented.
  - blk_last = 1 only in S_SEND_LAST and S_SEND_EXTRA.
- Latency: blk_valid rises the cycle after the accept that completes a block; the extra block is valid the cycle after S_SEND_PRE handshakes.
- Throughput: one input word per cycle in S_FILL. At least 1 bubble cycle per block; no input is accepted while a block is held.
- in_valid is ignored outside S_FILL. in_nbytes>4, or in_nbytes=0 without in_last, is undefined (the bench must not drive it).

Optional Feature:
- Macro: SHA_PAD_W64_EN.
- When defined:
  - Adds output port blk_w64 [0:63][31:0], the message schedule W[0..63] combinationally expanded from blk_data.
  - W[t] = W[0..15] for t<16.
  - W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] for t=16-63, mod 2^32.
  - sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10.
  - blk_w64 is valid whenever blk_valid=1, so it drives the full-schedule core input directly.
- When undefined: port absent; no schedule logic.

Test Plan:
- "abc": in_data=0x61626300, nbytes=3, last.
  - One block: word0=0x61626380, words1-14=0, word15=0x00000018, first=1, last=1.
  - With SHA_PAD_W64_EN, blk_w64 matches the software expansion.
- Empty message: in_nbytes=0, last, word 0.
  - One block: word0=0x80000000, words1-15=0, first=last=1.
- 56-byte message: 14 full words, last on word 13.
  - Block A: word14=0x80000000, word15=0, first=1, last=0.
  - Block B: words0-14=0, word15=0x000001C0, first=0, last=1.
- 64-byte message: 16 full words, last on word 15.
  - Block A: all data words, last=0.
  - Block B: word0=0x80000000, word15=0x00000200, last=1.
- Backpressure: blk_ready=0 for 10 cycles after blk_valid.
  - blk_data and flags stay stable, in_ready=0; one handshake when blk_ready=1.
- Reset mid-message: 5 words accepted, then reset for 1 cycle, then "abc".
  - Output is identical to the "abc" scenario, with no residue of the 5 words.
